// File: rtl/tensor_issue_arb.sv
// tensor_issue_arb: round-robin arbiter/sequencer sharing one 4-lane BF16
// tensor unit among four warp-slot requesters. One op in flight at a time;
// responses are tagged with the requester index and carry an error flag for
// illegal ops or a watchdog timeout.
module tensor_issue_arb #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [3*NREQ-1:0]    req_op,
  input  logic [64*NREQ-1:0]   req_a,
  input  logic [64*NREQ-1:0]   req_b,
  input  logic [64*NREQ-1:0]   req_acc,
  output logic                 tu_start,
  output logic [2:0]           tu_op,
  output logic [63:0]          tu_a,
  output logic [63:0]          tu_b,
  output logic [63:0]          tu_acc,
  input  logic [63:0]          tu_rd,
  input  logic                 tu_done,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_id,
  output logic [63:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam int IW = 2;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [2:0] OP_MAX = 3'd4;  // RELU is the highest legal code

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                  state, nxt;
  logic [IW-1:0]           last_grant;
  logic [CW-1:0]           wd_cnt;
  logic                    wd_expire;
  logic                    gnt_vld;
  logic [IW-1:0]           gnt_idx;
  logic [IW-1:0]           cand;
  logic                    legal;

  // per-requester views of the flat operand buses
  logic [NREQ-1:0][2:0]    op_v;
  logic [NREQ-1:0][63:0]   a_v, b_v, acc_v;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_v[i]  = req_op[3*i +: 3];
    assign a_v[i]   = req_a[64*i +: 64];
    assign b_v[i]   = req_b[64*i +: 64];
    assign acc_v[i] = req_acc[64*i +: 64];
  end

  // round-robin search: candidates closest after last_grant win; last_grant
  // itself is checked last (k == NREQ wraps back onto it)
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = last_grant + IW'(k);
      if (req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign legal     = (op_v[gnt_idx] <= OP_MAX);
  // counter was cleared in ISSUE, so it reaches TIMEOUT after TIMEOUT WAIT cycles
  assign wd_expire = (wd_cnt == CW'(TIMEOUT - 1));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next-state logic; done has priority over the watchdog
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (gnt_vld) nxt = legal ? ISSUE : RESP;
      ISSUE: nxt = WAIT;
      WAIT:  if (tu_done || wd_expire) nxt = RESP;
      RESP:  if (rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // state-decoded outputs; the request handshake is combinational in IDLE
  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_vld) req_ready[gnt_idx] = 1'b1;
    tu_start  = (state == ISSUE);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  // datapath: latch the granted request, run the watchdog, capture the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IW'(NREQ - 1);
      wd_cnt     <= '0;
      tu_op      <= '0;
      tu_a       <= '0;
      tu_b       <= '0;
      tu_acc     <= '0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          rsp_id <= gnt_idx;
          tu_op  <= op_v[gnt_idx];
          tu_a   <= a_v[gnt_idx];
          tu_b   <= b_v[gnt_idx];
          tu_acc <= acc_v[gnt_idx];
          if (!legal) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        ISSUE: wd_cnt <= '0;
        WAIT: begin
          wd_cnt <= wd_cnt + CW'(1);
          if (tu_done) begin
            rsp_data <= tu_rd;
            rsp_err  <= 1'b0;
          end else if (wd_expire) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        RESP: if (rsp_ready) last_grant <= rsp_id;
        default: ;
      endcase
    end
  end

endmodule
